// File: rtl/mdu_issue_ctrl.sv
// Issue/hold controller in front of the multi-cycle multiply/divide unit.
// It latches one op, holds the MDU request until data_ok, then holds the result until retirement.
package mdu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_MUL    = 4'd0,
    ALU_MULH   = 4'd1,
    ALU_MULHSU = 4'd2,
    ALU_MULHU  = 4'd3,
    ALU_DIV    = 4'd4,
    ALU_DIVU   = 4'd5,
    ALU_REM    = 4'd6,
    ALU_REMU   = 4'd7,
    ALU_MULW   = 4'd8,
    ALU_DIVW   = 4'd9,
    ALU_DIVUW  = 4'd10,
    ALU_REMW   = 4'd11,
    ALU_REMUW  = 4'd12
  } alufunc_t;
endpackage

module mdu_issue_ctrl
  import mdu_issue_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DST_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  alufunc_t         in_func,
  input  logic [DST_W-1:0] in_dst,
  output logic             mdu_valid,
  output logic [WIDTH-1:0] mdu_a,
  output logic [WIDTH-1:0] mdu_b,
  output alufunc_t         mdu_func,
  input  logic [WIDTH-1:0] mdu_result,
  input  logic             mdu_data_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [DST_W-1:0] out_dst,
  output logic             stall,
  output logic             err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s, nxt_s;
  logic             acc_s, cap_s, accept_s, capture_s;
  logic [WIDTH-1:0] a_r, b_r, result_r;
  alufunc_t         func_r;
  logic [DST_W-1:0] dst_r, out_dst_r;
  logic [7:0]       cnt_r, cnt_inc_s;
  logic             err_r;

  assign mdu_a      = a_r;
  assign mdu_b      = b_r;
  assign mdu_func   = func_r;
  assign out_result = result_r;
  assign out_dst    = out_dst_r;
  assign err        = err_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state and handshake decode; flush wins over every other input.
  always_comb begin
    nxt_s     = state_r;
    acc_s     = 1'b0;
    cap_s     = 1'b0;
    in_ready  = 1'b0;
    mdu_valid = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_s = 1'b1;
          nxt_s = BUSY;
        end else begin
          nxt_s = IDLE;
        end
      end
      BUSY: begin
        mdu_valid = 1'b1;
        if (mdu_data_ok) begin
          cap_s = 1'b1;
          nxt_s = DONE;
        end else begin
          nxt_s = BUSY;
        end
      end
      DONE: begin
        // Passing through DONE keeps mdu_valid low for a cycle so the MDU restarts.
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && in_valid) begin
          acc_s = 1'b1;
          nxt_s = BUSY;
        end else if (out_ready) begin
          nxt_s = IDLE;
        end else begin
          nxt_s = DONE;
        end
      end
      default: nxt_s = IDLE;
    endcase
    state_s   = flush ? IDLE : nxt_s;
    accept_s  = acc_s & ~flush;
    capture_s = cap_s & ~flush;
    stall     = (state_r == BUSY) | ((state_r == DONE) & ~out_ready) | (in_valid & ~in_ready);
  end

  // Operand latch and result hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      func_r    <= ALU_MUL;
      dst_r     <= {DST_W{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      out_dst_r <= {DST_W{1'b0}};
    end else begin
      if (accept_s) begin
        a_r    <= in_a;
        b_r    <= in_b;
        func_r <= in_func;
        dst_r  <= in_dst;
      end
      if (capture_s) begin
        result_r  <= mdu_result;
        out_dst_r <= dst_r;
      end
    end
  end

  assign cnt_inc_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;

  // Busy-cycle watchdog; err is sticky until reset, flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 8'd0;
      err_r <= 1'b0;
    end else begin
      if ((state_r == BUSY) && !flush && !mdu_data_ok) cnt_r <= cnt_inc_s;
      else                                             cnt_r <= 8'd0;
      if ((state_r == BUSY) && (cnt_inc_s >= TIMEOUT_C)) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: cycle checks in the stimulus thread, results checked
// by a scoreboard monitor that pops an expected entry on every out_valid/out_ready handshake.
module tb_mdu_issue_ctrl;
  import mdu_issue_pkg::*;

  localparam int WIDTH = 64;
  localparam int DST_W = 5;

  logic             clk, reset, flush;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  alufunc_t         in_func, mdu_func;
  logic [DST_W-1:0] in_dst, out_dst;
  logic             mdu_valid, mdu_data_ok;
  logic [WIDTH-1:0] mdu_a, mdu_b, mdu_result, out_result;
  logic             out_valid, out_ready, stall, err;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [DST_W-1:0] dst;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  mdu_issue_ctrl #(.WIDTH(WIDTH), .DST_W(DST_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_dst(in_dst),
    .mdu_valid(mdu_valid), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_func(mdu_func),
    .mdu_result(mdu_result), .mdu_data_ok(mdu_data_ok),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst),
    .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input alufunc_t f,
                          input logic [4:0] d);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_func  = f;
    in_dst   = d;
  endtask

  task automatic clear_in();
    in_valid = 1'b0;
    in_a     = 64'd0;
    in_b     = 64'd0;
    in_func  = ALU_MUL;
    in_dst   = 5'd0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_out: got result %0h dst %0d, required no output", out_result, out_dst);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", out_result, e.result);
        check("sb_dst", 64'(out_dst), 64'(e.dst));
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    mdu_data_ok = 1'b0; mdu_result = 64'd0;
    clear_in();
    step(); step();
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mdu_valid", 64'(mdu_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    reset = 1'b0;
    step();

    // MUL 3*5, data_ok in the 4th BUSY cycle
    drive_op(64'd3, 64'd5, ALU_MUL, 5'd7);
    sb_q.push_back('{result: 64'd15, dst: 5'd7});
    #1;
    check("mul_c0_in_ready", 64'(in_ready), 64'd1);
    check("mul_c0_stall", 64'(stall), 64'd0);
    step();
    clear_in();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        mdu_data_ok = 1'b1;
        mdu_result  = 64'd15;
      end
      #1;
      check("mul_busy_mdu_valid", 64'(mdu_valid), 64'd1);
      check("mul_busy_mdu_a", mdu_a, 64'd3);
      check("mul_busy_mdu_b", mdu_b, 64'd5);
      check("mul_busy_mdu_func", 64'(mdu_func), 64'(ALU_MUL));
      check("mul_busy_stall", 64'(stall), 64'd1);
      check("mul_busy_in_ready", 64'(in_ready), 64'd0);
      check("mul_busy_out_valid", 64'(out_valid), 64'd0);
      step();
    end
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    #1;
    check("mul_c5_out_valid", 64'(out_valid), 64'd1);
    check("mul_c5_mdu_valid", 64'(mdu_valid), 64'd0);
    check("mul_c5_out_result", out_result, 64'd15);
    step();
    #1;
    check("mul_c6_out_valid", 64'(out_valid), 64'd0);
    check("mul_c6_in_ready", 64'(in_ready), 64'd1);

    // DIV by zero answered in the first BUSY cycle
    drive_op(64'd100, 64'd0, ALU_DIV, 5'd3);
    sb_q.push_back('{result: 64'hFFFF_FFFF_FFFF_FFFF, dst: 5'd3});
    step();
    clear_in();
    mdu_data_ok = 1'b1;
    mdu_result  = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("div_c1_mdu_valid", 64'(mdu_valid), 64'd1);
    check("div_c1_mdu_b", mdu_b, 64'd0);
    step();
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    #1;
    check("div_c2_out_valid", 64'(out_valid), 64'd1);
    check("div_c2_out_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // Backpressure in DONE, then retire and accept back-to-back
    out_ready = 1'b0;
    drive_op(64'd6, 64'd7, ALU_MULW, 5'd9);
    sb_q.push_back('{result: 64'd42, dst: 5'd9});
    step();
    clear_in();
    mdu_data_ok = 1'b1;
    mdu_result  = 64'd42;
    step();
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_result", out_result, 64'd42);
      check("bp_out_dst", 64'(out_dst), 64'd9);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_stall", 64'(stall), 64'd1);
      check("bp_mdu_valid", 64'(mdu_valid), 64'd0);
      step();
    end
    out_ready = 1'b1;
    drive_op(64'd10, 64'd2, ALU_DIVU, 5'd4);
    sb_q.push_back('{result: 64'd5, dst: 5'd4});
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_mdu_valid", 64'(mdu_valid), 64'd0);
    check("bp_release_stall", 64'(stall), 64'd0);
    step();
    clear_in();
    mdu_data_ok = 1'b1;
    mdu_result  = 64'd5;
    #1;
    check("b2b_mdu_valid", 64'(mdu_valid), 64'd1);
    check("b2b_mdu_a", mdu_a, 64'd10);
    check("b2b_mdu_func", 64'(mdu_func), 64'(ALU_DIVU));
    check("b2b_out_valid", 64'(out_valid), 64'd0);
    step();
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    #1;
    check("b2b_out_valid_done", 64'(out_valid), 64'd1);
    step();

    // Flush in the 2nd BUSY cycle together with data_ok
    drive_op(64'd1, 64'd2, ALU_MUL, 5'd1);
    step();
    clear_in();
    step();
    flush       = 1'b1;
    mdu_data_ok = 1'b1;
    mdu_result  = 64'd2;
    step();
    flush       = 1'b0;
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_mdu_valid", 64'(mdu_valid), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_stall", 64'(stall), 64'd0);
      step();
    end

    // Watchdog with TIMEOUT=8, data_ok never arrives
    drive_op(64'd11, 64'd13, ALU_REM, 5'd6);
    step();
    clear_in();
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("wd_err_low", 64'(err), 64'd0);
      check("wd_mdu_valid", 64'(mdu_valid), 64'd1);
      step();
    end
    #1;
    check("wd_err_set", 64'(err), 64'd1);
    check("wd_still_busy", 64'(mdu_valid), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("wd_err_after_flush", 64'(err), 64'd1);
      check("wd_in_ready_after_flush", 64'(in_ready), 64'd1);
      step();
    end

    // Asynchronous reset in the middle of a BUSY cycle
    drive_op(64'd21, 64'd22, ALU_MULHU, 5'd2);
    step();
    clear_in();
    #1;
    check("arst_pre_mdu_valid", 64'(mdu_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_mdu_valid", 64'(mdu_valid), 64'd0);
    check("arst_mdu_a", mdu_a, 64'd0);
    check("arst_err", 64'(err), 64'd0);
    step();
    reset       = 1'b0;
    mdu_data_ok = 1'b1;
    mdu_result  = 64'd77;
    step();
    mdu_data_ok = 1'b0;
    mdu_result  = 64'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("arst_no_out_valid", 64'(out_valid), 64'd0);
      step();
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
